clk_div_prog: RTL and testbench

CLK_DIV_PROG -- requirements
Module: clk_div_prog

---
 rtl/clk_div_prog_if.sv | 23 ++
 rtl/clk_div_prog.sv | 104 ++++++++++
 tb/tb_clk_div_prog.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/clk_div_prog_if.sv
// Control/status bundle for the programmable clock divider: enable, settings
// load request, and the registered divided outputs.
interface clk_div_prog_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic             load;
    logic [WIDTH-1:0] div_in;
    logic [WIDTH-1:0] high_in;
    logic             clk_out;
    logic             tick;
    logic             pending;

    modport master (
        output en, load, div_in, high_in,
        input  clk_out, tick, pending
    );

    modport slave (
        input  en, load, div_in, high_in,
        output clk_out, tick, pending
    );
endinterface

// File: rtl/clk_div_prog.sv
// Programmable divider producing a registered enable-style waveform in the clk
// domain; new settings are staged in a shadow and applied only at a period boundary.
module clk_div_prog #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 4
) (
    input  logic           clk,
    input  logic           rst,
    clk_div_prog_if.slave  bus
);
    localparam logic [WIDTH-1:0] DEF_DIV  = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] DEF_HIGH = WIDTH'(DEFAULT_DIV / 2);
    localparam logic [WIDTH-1:0] DEF_PH   = WIDTH'(DEFAULT_DIV - 1);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO      = WIDTH'(2);

    logic [WIDTH-1:0] ph_q, ph_d;
    logic [WIDTH-1:0] div_a_q, div_a_d;
    logic [WIDTH-1:0] high_a_q, high_a_d;
    logic [WIDTH-1:0] div_s_q, div_s_d;
    logic [WIDTH-1:0] high_s_q, high_s_d;
    logic             pending_q, pending_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;

    logic [WIDTH-1:0] div_c;
    logic [WIDTH-1:0] high_c;
    logic             boundary;
    logic             apply;

    // Clamp so every captured setting gives a waveform that actually toggles.
    always_comb begin
        div_c = bus.div_in;
        if (bus.div_in < TWO) begin
            div_c = TWO;
        end
        high_c = bus.high_in;
        if (bus.high_in == '0) begin
            high_c = div_c >> 1;
        end else if (bus.high_in >= div_c) begin
            high_c = div_c - ONE;
        end
    end

    always_comb begin
        ph_d      = ph_q;
        div_a_d   = div_a_q;
        high_a_d  = high_a_q;
        div_s_d   = div_s_q;
        high_s_d  = high_s_q;
        pending_d = pending_q;
        clk_out_d = clk_out_q;
        tick_d    = 1'b0;

        boundary = bus.en && (ph_q == div_a_q - ONE);
        // A load landing on the boundary itself defers to the next boundary.
        apply    = boundary && pending_q && !bus.load;

        if (bus.load) begin
            div_s_d   = div_c;
            high_s_d  = high_c;
            pending_d = 1'b1;
        end else if (apply) begin
            pending_d = 1'b0;
        end

        if (apply) begin
            div_a_d  = div_s_q;
            high_a_d = high_s_q;
        end

        if (bus.en) begin
            ph_d      = boundary ? '0 : ph_q + ONE;
            clk_out_d = (ph_d < high_a_d);
            tick_d    = (ph_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ph_q      <= DEF_PH;
            div_a_q   <= DEF_DIV;
            high_a_q  <= DEF_HIGH;
            div_s_q   <= DEF_DIV;
            high_s_q  <= DEF_HIGH;
            pending_q <= 1'b0;
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            ph_q      <= ph_d;
            div_a_q   <= div_a_d;
            high_a_q  <= high_a_d;
            div_s_q   <= div_s_d;
            high_s_q  <= high_s_d;
            pending_q <= pending_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
        end
    end

    assign bus.clk_out = clk_out_q;
    assign bus.tick    = tick_q;
    assign bus.pending = pending_q;
endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog: directed scenarios with literal patterns
// plus randomized traffic checked every cycle against a position-in-period model.
module tb_clk_div_prog;
    localparam int W = 8;
    localparam int DEF = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;
    bit   chk_on = 1'b0;

    // model: position within the current period plus active/staged settings
    int m_pos, m_div, m_high, m_sdiv, m_shigh;
    bit m_pend, m_clk, m_tick;

    logic [31:0] cap, tcap;

    clk_div_prog_if #(.WIDTH(W)) bif ();

    clk_div_prog #(.WIDTH(W), .DEFAULT_DIV(DEF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Next-cycle behaviour derived from the period rules using the inputs about to be clocked.
    task automatic model_step();
        int d, h;
        bit wrap, take;
        if (rst) begin
            m_pos = DEF - 1; m_div = DEF; m_high = DEF / 2;
            m_sdiv = DEF; m_shigh = DEF / 2;
            m_pend = 0; m_clk = 0; m_tick = 0;
            return;
        end
        wrap = bif.en && (m_pos + 1 == m_div);
        take = wrap && m_pend && !bif.load;
        if (take) begin
            m_div = m_sdiv; m_high = m_shigh; m_pend = 0;
        end
        if (bif.load) begin
            d = (int'(bif.div_in) < 2) ? 2 : int'(bif.div_in);
            h = int'(bif.high_in);
            if (h == 0) h = d / 2;
            else if (h >= d) h = d - 1;
            m_sdiv = d; m_shigh = h; m_pend = 1;
        end
        m_tick = 0;
        if (bif.en) begin
            m_pos  = wrap ? 0 : m_pos + 1;
            m_clk  = (m_pos < m_high);
            m_tick = (m_pos == 0);
        end
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        cap  = {cap[30:0], bif.clk_out};
        tcap = {tcap[30:0], bif.tick};
        if (chk_on) begin
            check("cyc_clk_out", int'(bif.clk_out), int'(m_clk));
            check("cyc_tick", int'(bif.tick), int'(m_tick));
            check("cyc_pending", int'(bif.pending), int'(m_pend));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; bif.en = 1'b0; bif.load = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
        cap = '0; tcap = '0;
    endtask

    task automatic set_load(input int d, input int h);
        bif.load = 1'b1; bif.div_in = W'(d); bif.high_in = W'(h);
    endtask

    initial begin
        bif.en = 1'b0; bif.load = 1'b0; bif.div_in = '0; bif.high_in = '0;
        rst = 1'b1;
        model_step();
        @(posedge clk); #1;
        chk_on = 1'b1;

        // reset state and default waveform
        do_reset();
        check("rst_clk_out", int'(bif.clk_out), 0);
        check("rst_tick", int'(bif.tick), 0);
        check("rst_pending", int'(bif.pending), 0);
        bif.en = 1'b1;
        repeat (8) cyc();
        check("default_wave", int'(cap[7:0]), int'(8'b11001100));
        check("default_tick", int'(tcap[7:0]), int'(8'b10001000));

        // load 5/2 mid-period
        do_reset();
        bif.en = 1'b1;
        cyc(); cyc();
        set_load(5, 2);
        cyc();
        bif.load = 1'b0;
        check("load_pending_set", int'(bif.pending), 1);
        cyc(); cyc();
        check("load_pending_clr", int'(bif.pending), 0);
        repeat (6) cyc();
        check("load_5_2_wave", int'(cap[10:0]), int'(11'b11001100011));

        // clamping, loaded while disabled
        do_reset();
        set_load(0, 0); cyc(); bif.load = 1'b0;
        check("clamp_pending_en0", int'(bif.pending), 1);
        cap = '0; bif.en = 1'b1;
        repeat (6) cyc();
        check("clamp_0_0", int'(cap[5:0]), int'(6'b101010));

        do_reset();
        set_load(7, 0); cyc(); bif.load = 1'b0;
        cap = '0; bif.en = 1'b1;
        repeat (8) cyc();
        check("clamp_7_0", int'(cap[7:0]), int'(8'b11100001));

        do_reset();
        set_load(3, 9); cyc(); bif.load = 1'b0;
        cap = '0; bif.en = 1'b1;
        repeat (6) cyc();
        check("clamp_3_9", int'(cap[5:0]), int'(6'b110110));

        // enable held low during the high phase
        do_reset();
        bif.en = 1'b1; cyc();
        bif.en = 1'b0; repeat (3) cyc();
        bif.en = 1'b1; repeat (4) cyc();
        check("en_hold_wave", int'(cap[7:0]), int'(8'b11111001));
        check("en_hold_tick", int'(tcap[7:0]), int'(8'b10000001));

        // load on a boundary edge then overwrite one cycle later
        do_reset();
        bif.en = 1'b1;
        repeat (4) cyc();
        set_load(6, 0); cyc();
        set_load(8, 0); cyc();
        bif.load = 1'b0;
        repeat (10) cyc();
        check("boundary_load_wave", int'(cap[15:0]), int'(16'b1100110011110000));
        check("boundary_load_tick", int'(tcap[15:0]), int'(16'b1000100010000000));
        check("boundary_load_pend", int'(bif.pending), 0);

        // reset mid-period with a pending setting
        do_reset();
        bif.en = 1'b1; cyc();
        set_load(5, 2); cyc(); bif.load = 1'b0;
        check("midrst_pend_before", int'(bif.pending), 1);
        rst = 1'b1; cyc(); rst = 1'b0;
        check("midrst_clk_out", int'(bif.clk_out), 0);
        check("midrst_tick", int'(bif.tick), 0);
        check("midrst_pending", int'(bif.pending), 0);
        cap = '0;
        repeat (4) cyc();
        check("midrst_restart", int'(cap[3:0]), int'(4'b1100));

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            rst      = ($urandom_range(0, 99) == 0);
            bif.en   = ($urandom_range(0, 4) != 0);
            bif.load = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 1) == 0) begin
                bif.div_in  = W'($urandom_range(0, 12));
                bif.high_in = W'($urandom_range(0, 14));
            end else begin
                bif.div_in  = W'($urandom);
                bif.high_in = W'($urandom);
            end
            cyc();
        end
        rst = 1'b0; bif.load = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
